rotating_square_gen: RTL and testbench

Pattern source for the 4-digit seven-segment display: generates a square that circulates around the display perimeter. The block produces four 7-bit segment patterns, `seg0_o` to `seg3_o`. It sits directly upstream of the display time multiplexer and drives that multiplexer's `in0_i` to `in3_i` inputs one-to-one. A prescaler sets the rotation speed. Enable and direction inputs are provided so the square can be paused and reversed.

---
 rtl/rotating_square_gen.sv | 85 ++++++++
 tb/tb_rotating_square_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rotating_square_gen.sv
// Rotating square pattern source for a 4-digit seven-segment display.
// A prescaler paces a 3-bit position around the display perimeter, and that position is decoded into four registered segment patterns.
module rotating_square_gen #(
    parameter int DIV = 50_000_000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       cw_i,
    output logic [6:0] seg0_o,
    output logic [6:0] seg1_o,
    output logic [6:0] seg2_o,
    output logic [6:0] seg3_o,
    output logic [2:0] pos_o,
    output logic       step_o
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    localparam logic [6:0] SEG_UPPER = 7'h1C;
    localparam logic [6:0] SEG_LOWER = 7'h23;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       pos_q, pos_d;
    logic [27:0]      segs_q, segs_d;
    logic             step_q, step_d;
    logic             stepNow;

    // Packed as {digit3, digit2, digit1, digit0}. The top row runs left to right and the bottom row runs right to left.
    function automatic logic [27:0] decodePos(input logic [2:0] pos);
        logic [27:0] segs;
        segs = {4{SEG_BLANK}};
        case (pos)
            3'd0: segs[27:21] = SEG_UPPER;
            3'd1: segs[20:14] = SEG_UPPER;
            3'd2: segs[13:7]  = SEG_UPPER;
            3'd3: segs[6:0]   = SEG_UPPER;
            3'd4: segs[6:0]   = SEG_LOWER;
            3'd5: segs[13:7]  = SEG_LOWER;
            3'd6: segs[20:14] = SEG_LOWER;
            3'd7: segs[27:21] = SEG_LOWER;
            default: segs = {4{SEG_BLANK}};
        endcase
        return segs;
    endfunction

    // The patterns are decoded from the next position, so they change on the same edge as pos_o.
    always_comb begin
        stepNow = en_i && (cnt_q == CNT_MAX);
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        if (en_i) begin
            cnt_d = stepNow ? '0 : cnt_q + 1'b1;
        end
        if (stepNow) begin
            pos_d = cw_i ? pos_q + 3'd1 : pos_q - 3'd1;
        end
        segs_d = decodePos(pos_d);
        step_d = stepNow;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            pos_q  <= 3'd0;
            segs_q <= {SEG_UPPER, SEG_BLANK, SEG_BLANK, SEG_BLANK};
            step_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            segs_q <= segs_d;
            step_q <= step_d;
        end
    end

    assign seg3_o = segs_q[27:21];
    assign seg2_o = segs_q[20:14];
    assign seg1_o = segs_q[13:7];
    assign seg0_o = segs_q[6:0];
    assign pos_o  = pos_q;
    assign step_o = step_q;

endmodule

// File: tb/tb_rotating_square_gen.sv
// Self-checking bench for rotating_square_gen.
// The main instance uses DIV=4; a second instance with DIV=1 checks that it steps on every edge.
module tb_rotating_square_gen;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       en = 1'b0;
    logic       cw = 1'b1;
    logic [6:0] seg0, seg1, seg2, seg3;
    logic [2:0] pos;
    logic       step;

    logic       rst1N = 1'b0;
    logic       en1 = 1'b0;
    logic [6:0] seg0One, seg1One, seg2One, seg3One;
    logic [2:0] posOne;
    logic       stepOne;

    int assertCount = 0;
    int failCount   = 0;

    int   expCnt  = 0;
    int   expPos  = 0;
    logic expStep = 1'b0;

    always #5 clk = ~clk;

    rotating_square_gen #(.DIV(4)) u_dut (
        .clk_i (clk),
        .rst_ni(rstN),
        .en_i  (en),
        .cw_i  (cw),
        .seg0_o(seg0),
        .seg1_o(seg1),
        .seg2_o(seg2),
        .seg3_o(seg3),
        .pos_o (pos),
        .step_o(step)
    );

    rotating_square_gen #(.DIV(1)) u_dutOne (
        .clk_i (clk),
        .rst_ni(rst1N),
        .en_i  (en1),
        .cw_i  (1'b1),
        .seg0_o(seg0One),
        .seg1_o(seg1One),
        .seg2_o(seg2One),
        .seg3_o(seg3One),
        .pos_o (posOne),
        .step_o(stepOne)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference table written out by hand: {digit3, digit2, digit1, digit0}.
    function automatic logic [27:0] expSegs(input int p);
        case (p)
            0: return {7'h1C, 7'h7F, 7'h7F, 7'h7F};
            1: return {7'h7F, 7'h1C, 7'h7F, 7'h7F};
            2: return {7'h7F, 7'h7F, 7'h1C, 7'h7F};
            3: return {7'h7F, 7'h7F, 7'h7F, 7'h1C};
            4: return {7'h7F, 7'h7F, 7'h7F, 7'h23};
            5: return {7'h7F, 7'h7F, 7'h23, 7'h7F};
            6: return {7'h7F, 7'h23, 7'h7F, 7'h7F};
            default: return {7'h23, 7'h7F, 7'h7F, 7'h7F};
        endcase
    endfunction

    task automatic checkAll(input string tag);
        int nonBlank;
        nonBlank = int'(seg0 != 7'h7F) + int'(seg1 != 7'h7F) + int'(seg2 != 7'h7F) + int'(seg3 != 7'h7F);
        checkOutput({tag, "_pos"}, 32'(pos), 32'(expPos));
        checkOutput({tag, "_segs"}, 32'({seg3, seg2, seg1, seg0}), 32'(expSegs(expPos)));
        checkOutput({tag, "_step"}, 32'(step), 32'(expStep));
        checkOutput({tag, "_onehot"}, 32'(nonBlank), 32'd1);
    endtask

    // One clock edge: update the expected state from the inputs seen at the edge, then check 1 ns later.
    task automatic applyStimulus(input string tag);
        @(posedge clk);
        expStep = 1'b0;
        if (en) begin
            if (expCnt == 3) begin
                expCnt  = 0;
                expPos  = cw ? (expPos + 1) % 8 : (expPos + 7) % 8;
                expStep = 1'b1;
            end else begin
                expCnt++;
            end
        end
        #1;
        checkAll(tag);
    endtask

    initial begin
        int guard;
        logic [27:0] frozen;

        // Reset state
        #12;
        checkAll("reset");

        // First step lands on the 4th edge after release
        en = 1'b1;
        cw = 1'b1;
        rstN = 1'b1;
        applyStimulus("t1_e1");
        applyStimulus("t1_e2");
        applyStimulus("t1_e3");
        applyStimulus("t1_e4");
        checkOutput("t1_pos_is_1", 32'(pos), 32'd1);
        checkOutput("t1_seg2_upper", 32'(seg2), 32'h1C);
        applyStimulus("t1_e5");
        checkOutput("t1_step_one_cycle", 32'(step), 32'd0);

        // Full clockwise lap
        for (int i = 0; i < 32; i++) begin
            applyStimulus("t2_run");
            if (expPos == 4 && expStep) checkOutput("t2_seg0_lower", 32'(seg0), 32'h23);
            if (expPos == 7 && expStep) checkOutput("t2_seg3_lower", 32'(seg3), 32'h23);
        end

        guard = 0;
        while (!(expPos == 0 && expStep) && guard < 64) begin
            applyStimulus("t3_seek0");
            guard++;
        end
        checkOutput("t3_seek0_bound", 32'(guard < 64), 32'd1);

        // Counter-clockwise from 0
        cw = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus("t3_ccw_a");
        checkOutput("t3_pos_7", 32'(pos), 32'd7);
        checkOutput("t3_seg3_lower", 32'(seg3), 32'h23);
        for (int i = 0; i < 4; i++) applyStimulus("t3_ccw_b");
        checkOutput("t3_pos_6", 32'(pos), 32'd6);

        // Only the direction at the step edge matters
        cw = 1'b1;
        applyStimulus("t3_tog_a1");
        applyStimulus("t3_tog_a2");
        cw = 1'b0;
        applyStimulus("t3_tog_a3");
        applyStimulus("t3_tog_a4");
        checkOutput("t3_tog_pos_5", 32'(pos), 32'd5);
        cw = 1'b0;
        applyStimulus("t3_tog_b1");
        applyStimulus("t3_tog_b2");
        cw = 1'b1;
        applyStimulus("t3_tog_b3");
        applyStimulus("t3_tog_b4");
        checkOutput("t3_tog_pos_6", 32'(pos), 32'd6);

        // Pause with the counter at its terminal value
        guard = 0;
        while (expCnt != 3 && guard < 16) begin
            applyStimulus("t4_seek3");
            guard++;
        end
        checkOutput("t4_seek3_bound", 32'(guard < 16), 32'd1);
        frozen = {seg3, seg2, seg1, seg0};
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus("t4_hold");
            checkOutput("t4_frozen_segs", 32'({seg3, seg2, seg1, seg0}), 32'(frozen));
        end
        en = 1'b1;
        applyStimulus("t4_resume");
        checkOutput("t4_resume_step", 32'(step), 32'd1);
        checkOutput("t4_resume_pos", 32'(pos), 32'd7);

        // Asynchronous reset while step_o is high at pos 5
        guard = 0;
        while (!(expPos == 5 && expStep) && guard < 64) begin
            applyStimulus("t5_seek5");
            guard++;
        end
        checkOutput("t5_seek5_bound", 32'(guard < 64), 32'd1);
        #2;
        rstN = 1'b0;
        #1;
        expCnt = 0;
        expPos = 0;
        expStep = 1'b0;
        checkAll("t5_async_rst");
        @(posedge clk);
        #1;
        checkAll("t5_rst_held");
        rstN = 1'b1;
        applyStimulus("t5_e1");
        applyStimulus("t5_e2");
        applyStimulus("t5_e3");
        checkOutput("t5_no_early_step", 32'(pos), 32'd0);
        applyStimulus("t5_e4");
        checkOutput("t5_step_on_4th", 32'(pos), 32'd1);

        // DIV=1 steps on every enabled edge
        en1 = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t6_reset_pos", 32'(posOne), 32'd0);
        checkOutput("t6_reset_seg3", 32'(seg3One), 32'h1C);
        checkOutput("t6_reset_step", 32'(stepOne), 32'd0);
        rst1N = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            checkOutput("t6_pos", 32'(posOne), 32'(k % 8));
            checkOutput("t6_step", 32'(stepOne), 32'd1);
            checkOutput("t6_segs", 32'({seg3One, seg2One, seg1One, seg0One}), 32'(expSegs(k % 8)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
